// File: rtl/fb_rect_filler.sv
// Rectangle-fill write engine for the 320x240x12 framebuffer.
// Accepts one fill command, clips it to the right/bottom framebuffer edges
// and issues one write per covered pixel in row-major order.
module fb_rect_filler #(
   parameter int FB_WIDTH   = 320,
   parameter int FB_HEIGHT  = 240,
   parameter int ADDR_WIDTH = 17
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [8:0]            cmd_x,
   input  logic [7:0]            cmd_y,
   input  logic [8:0]            cmd_w,
   input  logic [7:0]            cmd_h,
   input  logic [11:0]           cmd_color,
   output logic                  fb_write_en,
   input  logic                  fb_write_ready,
   output logic [ADDR_WIDTH-1:0] fb_write_addr,
   output logic [11:0]           fb_write_data,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_FILL,
      ST_DONE
   } state_t;

   localparam logic [9:0]            FBW10 = 10'(FB_WIDTH);
   localparam logic [9:0]            FBH10 = 10'(FB_HEIGHT);
   localparam logic [ADDR_WIDTH-1:0] FBW_A = ADDR_WIDTH'(FB_WIDTH);

   state_t                  state;
   logic [8:0]              x_lat;
   logic [7:0]              y_lat;
   logic [8:0]              w_lat;
   logic [7:0]              h_lat;
   logic [11:0]             color_lat;
   logic [9:0]              x_end;
   logic [9:0]              y_end;
   logic [9:0]              col;
   logic [9:0]              row;
   logic [ADDR_WIDTH-1:0]   rowbase;

   logic [9:0]              x_sum;
   logic [9:0]              y_sum;
   logic [9:0]              x_end_c;
   logic [9:0]              y_end_c;
   logic                    degenerate;
   logic [ADDR_WIDTH-1:0]   rowbase_c;
   logic [ADDR_WIDTH-1:0]   x_addr;
   logic [9:0]              col_nxt;
   logic [9:0]              row_nxt;

   // Clip bounds, degenerate detection and the one-time row-base multiply
   always_comb begin
      x_sum      = {1'b0, x_lat} + {1'b0, w_lat};
      y_sum      = {2'b00, y_lat} + {2'b00, h_lat};
      x_end_c    = (x_sum > FBW10) ? FBW10 : x_sum;
      y_end_c    = (y_sum > FBH10) ? FBH10 : y_sum;
      degenerate = (w_lat == '0) || (h_lat == '0) ||
                   ({1'b0, x_lat} >= FBW10) || ({2'b00, y_lat} >= FBH10);
      rowbase_c  = ADDR_WIDTH'(y_lat) * FBW_A;
      x_addr     = ADDR_WIDTH'(x_lat);
      col_nxt    = col + 10'd1;
      row_nxt    = row + 10'd1;
   end

   // Command FSM with registered handshake and write-port outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         cmd_ready     <= 1'b1;
         fb_write_en   <= 1'b0;
         fb_write_addr <= '0;
         fb_write_data <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         x_lat         <= '0;
         y_lat         <= '0;
         w_lat         <= '0;
         h_lat         <= '0;
         color_lat     <= '0;
         x_end         <= '0;
         y_end         <= '0;
         col           <= '0;
         row           <= '0;
         rowbase       <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  x_lat     <= cmd_x;
                  y_lat     <= cmd_y;
                  w_lat     <= cmd_w;
                  h_lat     <= cmd_h;
                  color_lat <= cmd_color;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  state     <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               x_end <= x_end_c;
               y_end <= y_end_c;
               if (degenerate) begin
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  col           <= {1'b0, x_lat};
                  row           <= {2'b00, y_lat};
                  rowbase       <= rowbase_c;
                  fb_write_addr <= rowbase_c + x_addr;
                  fb_write_data <= color_lat;
                  fb_write_en   <= 1'b1;
                  state         <= ST_FILL;
               end
            end
            ST_FILL: begin
               if (fb_write_ready) begin
                  if (col_nxt < x_end) begin
                     col           <= col_nxt;
                     fb_write_addr <= fb_write_addr + ADDR_WIDTH'(1);
                  end else if (row_nxt < y_end) begin
                     // Row wrap folds the row step and column restart into
                     // one edge so a full-rate fill never bubbles.
                     col           <= {1'b0, x_lat};
                     row           <= row_nxt;
                     rowbase       <= rowbase + FBW_A;
                     fb_write_addr <= rowbase + FBW_A + x_addr;
                  end else begin
                     fb_write_en <= 1'b0;
                     done        <= 1'b1;
                     state       <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               done      <= 1'b0;
               busy      <= 1'b0;
               cmd_ready <= 1'b1;
               state     <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fb_rect_filler.sv
// Directed bench for fb_rect_filler: normal fill, clipping, degenerate
// commands, write backpressure, busy rejection and reset mid-fill.
module tb_fb_rect_filler;

   logic        clk;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [8:0]  cmd_x;
   logic [7:0]  cmd_y;
   logic [8:0]  cmd_w;
   logic [7:0]  cmd_h;
   logic [11:0] cmd_color;
   logic        fb_write_en;
   logic        fb_write_ready;
   logic [16:0] fb_write_addr;
   logic [11:0] fb_write_data;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   logic [16:0] acc[$];
   logic [16:0] pres[$];
   int          first_wr;
   int          done_cyc;
   int          done_cnt;
   int          rdy_cyc;
   int          data_bad;
   logic [11:0] exp_color;
   int          pat[8];
   int          npat;
   logic        nxt_valid;
   logic [8:0]  nxt_x;
   logic [7:0]  nxt_y;
   logic [8:0]  nxt_w;
   logic [7:0]  nxt_h;
   logic [11:0] nxt_color;
   logic [16:0] exp_list[$];

   fb_rect_filler #(
      .FB_WIDTH  (320),
      .FB_HEIGHT (240),
      .ADDR_WIDTH(17)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_x         (cmd_x),
      .cmd_y         (cmd_y),
      .cmd_w         (cmd_w),
      .cmd_h         (cmd_h),
      .cmd_color     (cmd_color),
      .fb_write_en   (fb_write_en),
      .fb_write_ready(fb_write_ready),
      .fb_write_addr (fb_write_addr),
      .fb_write_data (fb_write_data),
      .busy          (busy),
      .done          (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Present a command at a negedge so the next posedge accepts it.
   task automatic issue(input logic [8:0] x, input logic [7:0] y, input logic [8:0] w,
                        input logic [7:0] h, input logic [11:0] c);
      @(negedge clk);
      cmd_x          = x;
      cmd_y          = y;
      cmd_w          = w;
      cmd_h          = h;
      cmd_color      = c;
      cmd_valid      = 1'b1;
      fb_write_ready = 1'b1;
      exp_color      = c;
   endtask

   // Observe one command from the cycle after acceptance (c=0) until cmd_ready returns.
   task automatic collect(input int max_cyc);
      int k;
      acc.delete();
      pres.delete();
      first_wr = -1;
      done_cyc = -1;
      done_cnt = 0;
      rdy_cyc  = -1;
      data_bad = 0;
      k        = 0;
      for (int c = 0; c < max_cyc; c++) begin
         @(negedge clk);
         if (c == 0) begin
            cmd_valid = nxt_valid;
            if (nxt_valid) begin
               cmd_x     = nxt_x;
               cmd_y     = nxt_y;
               cmd_w     = nxt_w;
               cmd_h     = nxt_h;
               cmd_color = nxt_color;
            end
         end
         if (fb_write_en) begin
            if (first_wr < 0) first_wr = c;
            pres.push_back(fb_write_addr);
            if (fb_write_data !== exp_color) data_bad++;
            fb_write_ready = (k < npat) ? pat[k][0] : 1'b1;
            k++;
            if (fb_write_ready) acc.push_back(fb_write_addr);
         end else begin
            fb_write_ready = 1'b1;
         end
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (cmd_ready) begin
            rdy_cyc = c;
            chk("busy_low_at_ready", 32'(busy), 32'd0);
            break;
         end
      end
   endtask

   task automatic chk_list(input string tag, input logic [16:0] got[$], input logic [16:0] want[$]);
      chk({tag, "_count"}, 32'(got.size()), 32'(want.size()));
      for (int i = 0; i < want.size() && i < got.size(); i++)
         chk(tag, 32'(got[i]), 32'(want[i]));
   endtask

   initial begin
      reset          = 1'b1;
      cmd_valid      = 1'b0;
      cmd_x          = '0;
      cmd_y          = '0;
      cmd_w          = '0;
      cmd_h          = '0;
      cmd_color      = '0;
      fb_write_ready = 1'b1;
      npat           = 0;
      nxt_valid      = 1'b0;
      nxt_x          = '0;
      nxt_y          = '0;
      nxt_w          = '0;
      nxt_h          = '0;
      nxt_color      = '0;
      exp_color      = '0;
      foreach (pat[i]) pat[i] = 1;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_en", 32'(fb_write_en), 32'd0);
      chk("rst_addr", 32'(fb_write_addr), 32'd0);
      chk("rst_data", 32'(fb_write_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      reset = 1'b0;

      // Basic 3x2 fill at (10,20): row base 20*320 = 6400
      issue(9'd10, 8'd20, 9'd3, 8'd2, 12'hF00);
      collect(40);
      exp_list = '{17'd6410, 17'd6411, 17'd6412, 17'd6730, 17'd6731, 17'd6732};
      chk_list("basic_addr", acc, exp_list);
      chk("basic_first", 32'(first_wr), 32'd1);
      chk("basic_done_cyc", 32'(done_cyc), 32'd7);
      chk("basic_done_cnt", 32'(done_cnt), 32'd1);
      chk("basic_rdy_cyc", 32'(rdy_cyc), 32'd8);
      chk("basic_data", 32'(data_bad), 32'd0);

      // Bottom-right clip: only (318,239) and (319,239)
      issue(9'd318, 8'd239, 9'd5, 8'd4, 12'h0F0);
      collect(40);
      exp_list = '{17'd76798, 17'd76799};
      chk_list("clip_addr", acc, exp_list);
      chk("clip_done_cyc", 32'(done_cyc), 32'd3);
      chk("clip_data", 32'(data_bad), 32'd0);

      // Degenerate: zero width
      issue(9'd5, 8'd5, 9'd0, 8'd3, 12'h00F);
      collect(20);
      chk("degw_writes", 32'(pres.size()), 32'd0);
      chk("degw_done_cyc", 32'(done_cyc), 32'd1);
      chk("degw_rdy_cyc", 32'(rdy_cyc), 32'd2);

      // Degenerate: origin off the right edge
      issue(9'd320, 8'd5, 9'd4, 8'd4, 12'h00F);
      collect(20);
      chk("degx_writes", 32'(pres.size()), 32'd0);
      chk("degx_done_cyc", 32'(done_cyc), 32'd1);
      chk("degx_rdy_cyc", 32'(rdy_cyc), 32'd2);

      // Backpressure with ready pattern 1,0,0,1,0,1,1
      pat  = '{1, 0, 0, 1, 0, 1, 1, 1};
      npat = 7;
      issue(9'd0, 8'd0, 9'd4, 8'd1, 12'h0A5);
      collect(40);
      npat = 0;
      exp_list = '{17'd0, 17'd1, 17'd1, 17'd1, 17'd2, 17'd2, 17'd3};
      chk_list("bp_presented", pres, exp_list);
      exp_list = '{17'd0, 17'd1, 17'd2, 17'd3};
      chk_list("bp_accepted", acc, exp_list);
      chk("bp_done_cyc", 32'(done_cyc), 32'd8);
      chk("bp_data", 32'(data_bad), 32'd0);

      // Busy rejection: second command held valid during the first fill
      nxt_valid = 1'b1;
      nxt_x     = 9'd1;
      nxt_y     = 8'd2;
      nxt_w     = 9'd3;
      nxt_h     = 8'd1;
      nxt_color = 12'hABC;
      issue(9'd100, 8'd100, 9'd2, 8'd2, 12'h123);
      collect(40);
      nxt_valid = 1'b0;
      exp_list = '{17'd32100, 17'd32101, 17'd32420, 17'd32421};
      chk_list("busyA_addr", acc, exp_list);
      chk("busyA_rdy_cyc", 32'(rdy_cyc), 32'd6);
      chk("busyA_data", 32'(data_bad), 32'd0);
      exp_color = 12'hABC;
      collect(40);
      exp_list = '{17'd641, 17'd642, 17'd643};
      chk_list("busyB_addr", acc, exp_list);
      chk("busyB_first", 32'(first_wr), 32'd1);
      chk("busyB_done_cyc", 32'(done_cyc), 32'd4);
      chk("busyB_data", 32'(data_bad), 32'd0);

      // Reset after 3 of 10 writes on row 1 (addresses 320..329)
      issue(9'd0, 8'd1, 9'd10, 8'd1, 12'hFFF);
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("mid_en", 32'(fb_write_en), 32'd1);
      chk("mid_addr", 32'(fb_write_addr), 32'd323);
      #2 reset = 1'b1;
      #1;
      chk("mrst_en", 32'(fb_write_en), 32'd0);
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_ready", 32'(cmd_ready), 32'd1);
      chk("mrst_addr", 32'(fb_write_addr), 32'd0);
      chk("mrst_done", 32'(done), 32'd0);
      @(negedge clk);
      chk("mrst_done_hold", 32'(done), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("mrst_done_after", 32'(done), 32'd0);
      chk("mrst_en_after", 32'(fb_write_en), 32'd0);

      // Fresh command after the mid-fill reset
      issue(9'd2, 8'd0, 9'd2, 8'd1, 12'h777);
      collect(40);
      exp_list = '{17'd2, 17'd3};
      chk_list("post_addr", acc, exp_list);
      chk("post_first", 32'(first_wr), 32'd1);
      chk("post_done_cyc", 32'(done_cyc), 32'd3);
      chk("post_data", 32'(data_bad), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
